// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide unit: operation encodings,
//   sequencer state codes, datapath width and small arithmetic helpers.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [2:0] op_t;

    localparam op_t OP_MULT  = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_DIV   = 3'd2;
    localparam op_t OP_DIVU  = 3'd3;
    localparam op_t OP_MTHI  = 3'd4;
    localparam op_t OP_MTLO  = 3'd5;

    typedef logic [2:0] state_t;

    // ST_FIN is the done cycle: new HI/LO are visible and a new start may be
    // accepted, exactly as in ST_IDLE.
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_MUL      = 3'd1;
    localparam state_t ST_DIV_INIT = 3'd2;
    localparam state_t ST_DIV_RUN  = 3'd3;
    localparam state_t ST_FIN      = 3'd4;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Full 64-bit product. Sign-extending both operands and keeping the low
    // 2*XLEN bits of the product yields the signed result when sx is set.
    function automatic logic [2*XLEN-1:0] mul64(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic            sx);
        logic [2*XLEN-1:0] ax;
        logic [2*XLEN-1:0] bx;
        ax = {{XLEN{sx & a[XLEN-1]}}, a};
        bx = {{XLEN{sx & b[XLEN-1]}}, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// -----------------------------------------------------------------------------
// muldiv_div_step
//   One combinational restoring-divide iteration on magnitudes. The pair
//   {rem, quo} is shifted left one bit; if the shifted remainder covers the
//   divisor it is reduced and a 1 enters the quotient, otherwise a 0.
// Ports
//   rem       in   partial remainder (always < divisor)
//   quo       in   dividend bits still to consume / quotient bits so far
//   divisor   in   divisor magnitude (non-zero)
//   rem_next  out  updated partial remainder
//   quo_next  out  updated quotient/dividend register
// -----------------------------------------------------------------------------
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // Because rem < divisor, shifted < 2*divisor: the top bit of diff is
        // a clean borrow flag.
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle HI/LO unit. Sequences MULT/MULTU and DIV/DIVU, executes
//   MTHI/MTLO and owns the architectural HI/LO registers. busy/done let the
//   control unit stall dependent instructions.
// Parameters
//   MUL_LATENCY  cycles from accepted start to done for MULT/MULTU (>=1)
//   DIV_CYCLES   restoring-divide iterations, one quotient bit each
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request, sampled only when busy=0
//   op           0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//   rs, rt       operands (latched at accept)
//   flush        abort in-flight op; also drops a same-cycle start
//   busy         op in flight
//   done         one-cycle pulse, first cycle new HI/LO are visible
//   div_by_zero  with done, DIV/DIVU had rt==0
//   hi, lo       architectural HI/LO
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + MUL_LATENCY + 1);
    // MUL occupies MUL_LATENCY-1 cycles; the counter runs down to zero.
    localparam logic [CNT_W-1:0] MUL_CNT_INIT =
        CNT_W'((MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  op_a_q, op_a_d;
    logic [XLEN-1:0]  op_b_q, op_b_d;
    logic             sx_q, sx_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;
    logic             accept;
    logic             quo_neg;
    logic             rem_neg;

    muldiv_div_step u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign busy        = (state_q == ST_MUL) || (state_q == ST_DIV_INIT) ||
                         (state_q == ST_DIV_RUN);
    assign done        = (state_q == ST_FIN);
    assign div_by_zero = done && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Unknown op codes are never accepted.
    assign accept  = start && !busy && !flush && (op <= OP_MTLO);
    assign quo_neg = sx_q && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1]);
    assign rem_neg = sx_q && op_a_q[XLEN-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sx_d    = sx_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul64(op_a_q, op_b_q, sx_q);
                    state_d      = ST_FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DIV_INIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = '0;
                    quo_d   = neg_if(op_a_q, sx_q && op_a_q[XLEN-1]);
                    dvs_d   = neg_if(op_b_q, sx_q && op_b_q[XLEN-1]);
                    cnt_d   = DIV_CNT_INIT;
                    state_d = ST_DIV_RUN;
                end
            end

            ST_DIV_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        // Sign fix rides on the final step so HI/LO change once.
                        lo_d    = neg_if(step_quo, quo_neg);
                        hi_d    = neg_if(step_rem, rem_neg);
                        state_d = ST_FIN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            default: begin
                // ST_IDLE and ST_FIN: ready for a new request.
                state_d = ST_IDLE;
                dbz_d   = 1'b0;
                if (accept) begin
                    op_a_d = rs;
                    op_b_d = rt;
                    sx_d   = (op == OP_MULT) || (op == OP_DIV);
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            if (MUL_LATENCY <= 1) begin
                                {hi_d, lo_d} = mul64(rs, rt, op == OP_MULT);
                                state_d      = ST_FIN;
                            end else begin
                                cnt_d   = MUL_CNT_INIT;
                                state_d = ST_MUL;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            if (rt == '0) begin
                                dbz_d   = 1'b1;
                                state_d = ST_FIN;
                            end else begin
                                state_d = ST_DIV_INIT;
                            end
                        end
                        OP_MTHI: begin
                            hi_d    = rs;
                            state_d = ST_FIN;
                        end
                        OP_MTLO: begin
                            lo_d    = rs;
                            state_d = ST_FIN;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sx_q    <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sx_q    <= sx_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed self-checking bench for muldiv_sequencer. Cycle numbers count
//   from the cycle in which start is driven (cycle 0).
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_bad    = 0;

    muldiv_sequencer #(
        .MUL_LATENCY (2),
        .DIV_CYCLES  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for done. At cycle poke a competing
    // MTLO 0xBAD start is driven; it must be ignored while busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output int lat, output int nbusy,
                          output logic dbz);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        step();
        start = 1'b0;
        rs    = 32'h5A5A_5A5A;
        rt    = 32'h0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 200) begin
            if (busy) nbusy++;
            if (lat == poke) begin
                start = 1'b1;
                op    = OP_MTLO;
                rs    = 32'h0000_0BAD;
            end
            step();
            start = 1'b0;
            lat++;
        end
        dbz = div_by_zero;
        if (!done) lat = -1;
    endtask

    int   lat;
    int   nbusy;
    logic dbz;
    int   ndone;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        rs    = '0;
        rt    = '0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;
        step();

        // 1. MULTU max*max
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, nbusy, dbz);
        check("multu_lat", lat, 2);
        check("multu_busy", nbusy, 1);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_done_busy", busy, 0);
        step();
        check("multu_done_pulse", done, 0);

        // 2. MULT -3*5 then MTHI
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, -1, lat, nbusy, dbz);
        check("mult_lat", lat, 2);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        run_op(OP_MTHI, 32'h0000_1234, 32'd0, -1, lat, nbusy, dbz);
        check("mthi_lat", lat, 1);
        check("mthi_busy", nbusy, 0);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'hFFFF_FFF1);

        // 3. DIV -7/2 with an ignored start at cycle 10
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, lat, nbusy, dbz);
        check("div_lat", lat, 34);
        check("div_busy", nbusy, 33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_dbz", dbz, 0);

        // 4. DIVU by zero, then most-negative / -1
        run_op(OP_DIVU, 32'd100, 32'd0, -1, lat, nbusy, dbz);
        check("dbz_lat", lat, 1);
        check("dbz_busy", nbusy, 0);
        check("dbz_flag", dbz, 1);
        check("dbz_hi", hi, 32'hFFFF_FFFF);
        check("dbz_lo", lo, 32'hFFFF_FFFD);
        step();
        check("dbz_pulse", div_by_zero, 0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, nbusy, dbz);
        check("ovf_lat", lat, 34);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);

        // 5a. flush mid-divide
        start = 1'b1;
        op    = OP_DIV;
        rs    = 32'd1000;
        rt    = 32'd7;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_after", busy, 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            step();
        end
        check("flush_no_done", ndone, 0);
        check("flush_hi", hi, 32'h0000_0000);
        check("flush_lo", lo, 32'h8000_0000);

        // flush and start together in idle: start dropped
        start = 1'b1;
        flush = 1'b1;
        op    = OP_MTHI;
        rs    = 32'h55;
        step();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_done", done, 0);
        check("flush_start_hi", hi, 32'h0000_0000);

        // 5b. reset mid-divide
        start = 1'b1;
        op    = OP_DIV;
        rs    = 32'd1000;
        rt    = 32'd7;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        step();

        // 6. back-to-back DIVU then MULTU started in the done cycle
        run_op(OP_DIVU, 32'd1000, 32'd7, -1, lat, nbusy, dbz);
        check("b2b_div_lat", lat, 34);
        check("b2b_div_lo", lo, 32'd142);
        check("b2b_div_hi", hi, 32'd6);
        run_op(OP_MULTU, 32'd6, 32'd7, -1, lat, nbusy, dbz);
        check("b2b_mul_lat", lat, 2);
        check("b2b_mul_hi", hi, 32'd0);
        check("b2b_mul_lo", lo, 32'd42);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
